rope_shot_controller: RTL
=========================

ROPE_SHOT_CONTROLLER -- requirements
Module: rope_shot_controller

Interface
REQ-001 Parameter SCREEN_TOP_Y, default 0, ceiling row the rope head stops at.
REQ-002 Parameter FLOOR_Y, default 447, rope base row; idle head position.
REQ-003 Parameter ROPE_SPEED, default 4, pixels the head rises per frame.
REQ-004 Parameter HOLD_FRAMES, default 30, frames the rope stays at the ceiling before vanishing.
REQ-005 Parameter PLAYER_WIDTH, default 32, player sprite width; rope column = playerX + PLAYER_WIDTH/2.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 startOfFrame  input  1  one-cycle pulse, once per video frame.
REQ-009 fire  input  1  fire button level, already debounced.
REQ-010 playerX  input  11  player top-left X.
REQ-011 ballHit  input  1  one-cycle pulse: rope collided with a ball.
REQ-012 ropeX  output  11  rope column (topLeftX for the rope drawer).
REQ-013 topY  output  11  current rope head row (topY for the rope drawer).
REQ-014 ropeActive  output  1  high while a shot is in flight or holding.
REQ-015 ropeDone  output  1  one-cycle pulse when a shot ends.

Function
REQ-016 All outputs SHALL be registered; no combinational input-to-output path.
REQ-017 States SHALL be IDLE, EXTEND, HOLD.
REQ-018 Fire edge = fire high this cycle and low in the previous registered sample; level-held fire SHALL NOT retrigger.
REQ-019 IDLE: topY = FLOOR_Y, ropeActive = 0; fire edge -> EXTEND on next edge, ropeX latched as (playerX + PLAYER_WIDTH/2) truncated to 11 bits, topY = FLOOR_Y, ropeActive = 1 (one-cycle latency).
REQ-020 ropeX SHALL hold its latched value for the whole shot, ignoring playerX changes.
REQ-021 EXTEND: on each startOfFrame, topY = topY - ROPE_SPEED; computed at 12 bits so no underflow wrap.
REQ-022 EXTEND: if topY - ROPE_SPEED <= SCREEN_TOP_Y, topY = SCREEN_TOP_Y (saturate), hold counter = HOLD_FRAMES, state -> HOLD.
REQ-023 HOLD: on each startOfFrame, if counter = 0 -> IDLE with ropeDone pulse; else counter decrements.
REQ-024 HOLD_FRAMES = 0: rope SHALL leave HOLD at the first startOfFrame after reaching the ceiling.
REQ-025 ballHit in EXTEND or HOLD -> IDLE next cycle, topY = FLOOR_Y, ropeActive = 0, ropeDone = 1 for one cycle.
REQ-026 ballHit and startOfFrame in the same cycle: ballHit SHALL win; no head movement.
REQ-027 ballHit in IDLE SHALL be ignored; no ropeDone.
REQ-028 Fire edges during EXTEND or HOLD SHALL be ignored, not queued.
REQ-029 Fire edge in the same cycle the FSM returns to IDLE SHALL be ignored; a new shot requires an edge while in IDLE.
REQ-030 ropeDone SHALL pulse exactly once per shot, on entry to IDLE.

Reset
REQ-031 On reset: state IDLE, topY = FLOOR_Y, ropeX = 0, ropeActive = 0, ropeDone = 0, hold counter = 0.
REQ-032 Previous fire sample SHALL reset to 1 so fire held through reset does not shoot.
REQ-033 Reset mid-shot SHALL abort the shot without a ropeDone pulse.

Verification
REQ-034 Reset, fire low, then fire edge with playerX = 100 -> next cycle ropeActive = 1, ropeX = 116, topY = 447.
REQ-035 Shot running, 111 startOfFrame pulses -> topY = 3, state EXTEND; 112th -> topY = 0, state HOLD.
REQ-036 In HOLD, 30 startOfFrame pulses -> still active; 31st -> ropeActive = 0, topY = 447, single-cycle ropeDone.
REQ-037 Head at topY = 203, ballHit coincident with startOfFrame -> next cycle topY = 447, ropeDone = 1, no 199 value seen.
REQ-038 fire held high across reset release and for 200 frames -> ropeActive stays 0; release then press -> shot starts.
REQ-039 fire edge during EXTEND and a second edge on the ropeDone cycle -> no new shot; edge one cycle later -> shot starts.

Source files
------------

// File: rtl/rope_shot_controller_if.sv
// Signal bundle between the game logic and the rope shot controller.
interface rope_shot_controller_if;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] playerX;
  logic        ballHit;
  logic [10:0] ropeX;
  logic [10:0] topY;
  logic        ropeActive;
  logic        ropeDone;

  modport master (
    output startOfFrame, fire, playerX, ballHit,
    input  ropeX, topY, ropeActive, ropeDone
  );

  modport slave (
    input  startOfFrame, fire, playerX, ballHit,
    output ropeX, topY, ropeActive, ropeDone
  );
endinterface

// File: rtl/rope_shot_controller.sv
// Rope shot: launches from the player column, rises once per frame,
// lingers at the ceiling, and ends on timeout or on a ball collision.
module rope_shot_controller #(
  parameter int unsigned SCREEN_TOP_Y = 0,
  parameter int unsigned FLOOR_Y      = 447,
  parameter int unsigned ROPE_SPEED   = 4,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned PLAYER_WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset,
  rope_shot_controller_if.slave bus
);

  localparam int unsigned CW = 11;
  localparam int unsigned HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXTEND = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [CW-1:0] FLOOR_ROW = CW'(FLOOR_Y);
  localparam logic [CW-1:0] CEIL_ROW  = CW'(SCREEN_TOP_Y);
  localparam logic [CW:0]   CEIL_CMP  = (CW+1)'(SCREEN_TOP_Y);
  localparam logic [CW:0]   SPEED_12  = (CW+1)'(ROPE_SPEED);
  localparam logic [CW-1:0] HALF_W    = CW'(PLAYER_WIDTH / 2);

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] top_y_q,  top_y_d;
  logic [CW-1:0] rope_x_q, rope_x_d;
  logic [HW-1:0] hold_q,   hold_d;
  logic          active_q, active_d;
  logic          done_q,   done_d;
  logic          fire_q;

  logic          fire_edge_c;
  logic [CW:0]   head_next_c;
  logic          at_ceiling_c;

  // Head step is taken at 12 bits so a step past row 0 shows up as bit 11.
  assign fire_edge_c  = bus.fire & ~fire_q;
  assign head_next_c  = {1'b0, top_y_q} - SPEED_12;
  assign at_ceiling_c = head_next_c[CW] | (head_next_c <= CEIL_CMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      top_y_q  <= FLOOR_ROW;
      rope_x_q <= '0;
      hold_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      fire_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      top_y_q  <= top_y_d;
      rope_x_q <= rope_x_d;
      hold_q   <= hold_d;
      active_q <= active_d;
      done_q   <= done_d;
      fire_q   <= bus.fire;
    end
  end

  // Next-state and next-output logic; ballHit outranks frame ticks.
  always_comb begin
    state_d  = state_q;
    top_y_d  = top_y_q;
    rope_x_d = rope_x_q;
    hold_d   = hold_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        top_y_d = FLOOR_ROW;
        // The cycle showing ropeDone still belongs to the ending shot.
        if (fire_edge_c && !done_q) begin
          state_d  = EXTEND;
          rope_x_d = bus.playerX + HALF_W;
        end
      end
      EXTEND: begin
        if (bus.ballHit) begin
          state_d = IDLE;
          top_y_d = FLOOR_ROW;
          done_d  = 1'b1;
        end else if (bus.startOfFrame) begin
          if (at_ceiling_c) begin
            state_d = HOLD;
            top_y_d = CEIL_ROW;
            hold_d  = HW'(HOLD_FRAMES);
          end else begin
            top_y_d = head_next_c[CW-1:0];
          end
        end
      end
      HOLD: begin
        if (bus.ballHit) begin
          state_d = IDLE;
          top_y_d = FLOOR_ROW;
          done_d  = 1'b1;
        end else if (bus.startOfFrame) begin
          if (hold_q == '0) begin
            state_d = IDLE;
            top_y_d = FLOOR_ROW;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        top_y_d = FLOOR_ROW;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  assign bus.ropeX      = rope_x_q;
  assign bus.topY       = top_y_q;
  assign bus.ropeActive = active_q;
  assign bus.ropeDone   = done_q;

endmodule
